// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D-cache to physical-memory line arbiter.
// Holds the arbiter FSM states, the latched memory operation and the line-alignment helper.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_RD = 1'b0,
    ARB_WR = 1'b1
  } arb_op_t;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  // Physical memory only ever sees line-aligned addresses.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache miss ports.
// Data side wins ties unless instruction fetch has been passed over MAX_D_STREAK times in a row.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int LINE_W       = 256,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  arb_state_t          state, state_next;
  arb_op_t             op_q, op_next;
  logic [STREAK_W-1:0] streak, streak_next;
  logic [31:0]         addr_q, addr_next;
  logic [LINE_W-1:0]   wdata_q, wdata_next;
  logic                d_req;

  assign d_req = d_read | d_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= ARB_RD;
      streak  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_next;
      op_q    <= op_next;
      streak  <= streak_next;
      addr_q  <= addr_next;
      wdata_q <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state;
    op_next     = op_q;
    streak_next = streak;
    addr_next   = addr_q;
    wdata_next  = wdata_q;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    pmem_addr   = '0;
    pmem_wdata  = '0;
    i_resp      = 1'b0;
    i_rdata     = '0;
    d_resp      = 1'b0;
    d_rdata     = '0;

    case (state)
      IDLE: begin
        // I is only forced through once D has won STREAK_MAX contested rounds.
        if (d_req && !(i_read && streak == STREAK_MAX)) begin
          state_next = SERVE_D;
          addr_next  = line_align(d_addr);
          op_next    = d_write ? ARB_WR : ARB_RD;
          wdata_next = d_wdata;
          if (!i_read)
            streak_next = '0;
          else if (streak != STREAK_MAX)
            streak_next = streak + STREAK_ONE;
        end else if (i_read) begin
          state_next  = SERVE_I;
          addr_next   = line_align(i_addr);
          op_next     = ARB_RD;
          wdata_next  = '0;
          streak_next = '0;
        end
      end

      SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = addr_q;
        if (pmem_resp) begin
          i_resp     = 1'b1;
          i_rdata    = pmem_rdata;
          state_next = DONE;
        end
      end

      SERVE_D: begin
        pmem_read  = (op_q == ARB_RD);
        pmem_write = (op_q == ARB_WR);
        pmem_addr  = addr_q;
        pmem_wdata = wdata_q;
        if (pmem_resp) begin
          d_resp     = 1'b1;
          d_rdata    = pmem_rdata;
          state_next = DONE;
        end
      end

      // Turnaround cycle: a cache still holding its request after resp is not re-granted.
      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus a randomized run
// in which the bench plays both caches and memory against a transaction-level model.
module tb_cache_mem_arbiter;
  localparam int LINE_W = 256;
  localparam int MAX_D  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_read = 1'b0;
  logic [31:0]       i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [31:0]       d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  cache_mem_arbiter #(.LINE_W(LINE_W), .MAX_D_STREAK(MAX_D)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  task automatic apply_reset();
    reset = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0;
    i_read = 1; d_read = 1; i_addr = 32'h64; d_addr = 32'h80; pmem_resp = 1;
    pmem_rdata = {32{8'h5A}};
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    n_tests++;
    if (pmem_addr !== 32'h0 || pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      n_fail++; $display("FAIL reset_data: addr=%h expected 0 with all lines 0", pmem_addr);
    end
    apply_reset();
  endtask

  task automatic test_lone_i();
    apply_reset();
    tick();
    i_read = 1; i_addr = 32'h0000_0064;
    #1;
    n_tests++;
    if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL lone_i_early: pmem_read=%b expected 0", pmem_read); end
    tick();
    #1;
    n_tests++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 32'h0000_0060) begin
      n_fail++; $display("FAIL lone_i_req: rd=%b wr=%b addr=%h expected 1 0 00000060", pmem_read, pmem_write, pmem_addr);
    end
    pmem_resp = 1; pmem_rdata = {32{8'hA5}};
    #1;
    n_tests++;
    if (i_resp !== 1'b1 || i_rdata !== {32{8'hA5}} || d_resp !== 1'b0 || d_rdata !== '0) begin
      n_fail++; $display("FAIL lone_i_resp: i_resp=%b d_resp=%b i_rdata=%h expected 1 0 a5..a5", i_resp, d_resp, i_rdata);
    end
    tick();
    pmem_resp = 0; pmem_rdata = '0; i_read = 0;
    #1;
    n_tests++;
    if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
      n_fail++; $display("FAIL lone_i_done: rd=%b i_resp=%b expected 0 0", pmem_read, i_resp);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    tick();
    i_read = 1; i_addr = 32'h0000_0104; d_read = 1; d_addr = 32'h0000_0208;
    tick();
    #1;
    n_tests++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL simul_d_first: rd=%b addr=%h expected 1 00000200", pmem_read, pmem_addr);
    end
    pmem_resp = 1; pmem_rdata = mem_line(32'h200);
    #1;
    n_tests++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== mem_line(32'h200)) begin
      n_fail++; $display("FAIL simul_d_resp: d_resp=%b i_resp=%b expected 1 0", d_resp, i_resp);
    end
    tick();
    pmem_resp = 0; d_read = 0;
    tick();
    #1;
    n_tests++;
    if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL simul_gap: rd=%b expected 0", pmem_read); end
    tick();
    #1;
    n_tests++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL simul_i_second: rd=%b addr=%h expected 1 00000100", pmem_read, pmem_addr);
    end
    pmem_resp = 1; pmem_rdata = mem_line(32'h100);
    #1;
    n_tests++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== mem_line(32'h100)) begin
      n_fail++; $display("FAIL simul_i_resp: i_resp=%b d_resp=%b expected 1 0", i_resp, d_resp);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_starvation();
    logic exp_i;
    apply_reset();
    tick();
    i_read = 1; i_addr = 32'h0000_1000; d_read = 1; d_addr = 32'h0000_2000;
    for (int g = 0; g < 2 * (MAX_D + 1); g++) begin
      exp_i = ((g % (MAX_D + 1)) == MAX_D);
      tick();
      #1;
      n_tests++;
      if (pmem_read !== 1'b1 || pmem_addr !== (exp_i ? 32'h0000_1000 : 32'h0000_2000)) begin
        n_fail++; $display("FAIL starve_grant%0d: rd=%b addr=%h expected I=%b", g, pmem_read, pmem_addr, exp_i);
      end
      pmem_resp = 1; pmem_rdata = rand_line();
      #1;
      n_tests++;
      if (i_resp !== exp_i || d_resp !== !exp_i) begin
        n_fail++; $display("FAIL starve_resp%0d: i_resp=%b d_resp=%b expected I=%b", g, i_resp, d_resp, exp_i);
      end
      tick();
      pmem_resp = 0;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_writeback();
    logic [LINE_W-1:0] wd;
    apply_reset();
    for (int k = 0; k < LINE_W / 32; k++) wd[k*32 +: 32] = 32'h1234_5678 + 32'(k);
    tick();
    d_write = 1; d_addr = 32'h8000_0020; d_wdata = wd;
    tick();
    d_write = 0; d_read = 1; d_addr = 32'hFFFF_FFFF; d_wdata = rand_line();
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h8000_0020 || pmem_wdata !== wd) begin
        n_fail++; $display("FAIL wb_hold%0d: wr=%b rd=%b addr=%h expected 1 0 80000020", c, pmem_write, pmem_read, pmem_addr);
      end
      tick();
      d_addr = $urandom; d_wdata = rand_line();
    end
    pmem_resp = 1;
    #1;
    n_tests++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || pmem_wdata !== wd) begin
      n_fail++; $display("FAIL wb_resp: d_resp=%b i_resp=%b expected 1 0", d_resp, i_resp);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_held_and_spurious();
    apply_reset();
    tick();
    d_read = 1; d_addr = 32'h0000_0040;
    tick();
    pmem_resp = 1; pmem_rdata = mem_line(32'h40);
    #1;
    n_tests++;
    if (d_resp !== 1'b1) begin n_fail++; $display("FAIL held_first_resp: d_resp=%b expected 1", d_resp); end
    tick();
    pmem_resp = 1;
    #1;
    n_tests++;
    if (pmem_read !== 1'b0 || d_resp !== 1'b0) begin
      n_fail++; $display("FAIL held_done: rd=%b d_resp=%b expected 0 0", pmem_read, d_resp);
    end
    tick();
    d_read = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if (pmem_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
        n_fail++; $display("FAIL spurious%0d: rd=%b i_resp=%b d_resp=%b expected 0 0 0", c, pmem_read, i_resp, d_resp);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tick();
    d_read = 1; d_addr = 32'h0000_0300;
    tick();
    #1;
    n_tests++;
    if (pmem_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: rd=%b expected 1", pmem_read); end
    #1;
    reset = 0;
    #1;
    n_tests++;
    if (pmem_read !== 1'b0 || pmem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_drop: rd=%b addr=%h expected 0 0", pmem_read, pmem_addr);
    end
    pmem_resp = 1;
    #1;
    n_tests++;
    if (d_resp !== 1'b0) begin n_fail++; $display("FAIL rstmid_noresp: d_resp=%b expected 0", d_resp); end
    pmem_resp = 0; d_read = 0;
    @(negedge clk);
    reset = 1;
    tick();
    i_read = 1; i_addr = 32'h0000_0444;
    #1;
    n_tests++;
    if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: rd=%b expected 0", pmem_read); end
    tick();
    #1;
    n_tests++;
    if (pmem_read !== 1'b1 || pmem_addr !== 32'h0000_0440) begin
      n_fail++; $display("FAIL rstmid_regrant: rd=%b addr=%h expected 1 00000440", pmem_read, pmem_addr);
    end
    tick();
    clear_inputs();
  endtask

  // Bench plays both caches and memory; the model tracks transactions, not FSM states.
  task automatic test_random();
    logic i_pend, i_hold, d_pend, d_hold, d_wr;
    int   i_gap, d_gap;
    logic [31:0] ia, da;
    logic [LINE_W-1:0] dwd;
    logic busy, own_i, exp_wr;
    logic [31:0] exp_addr;
    logic [LINE_W-1:0] exp_wd;
    int start_cyc, resp_cyc, free_at, streak, lat;
    logic resp_now, ireq, dreq;
    apply_reset();
    i_pend = 0; i_hold = 0; d_pend = 0; d_hold = 0; d_wr = 0;
    i_gap = 0; d_gap = 1; ia = '0; da = '0; dwd = '0;
    busy = 0; own_i = 0; exp_wr = 0; exp_addr = '0; exp_wd = '0;
    start_cyc = 0; resp_cyc = 0; free_at = 0; streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      ireq = i_pend | i_hold;
      dreq = d_pend | d_hold;
      i_read = ireq; i_addr = ia;
      d_read = dreq & !d_wr; d_write = dreq & d_wr; d_addr = da; d_wdata = dwd;
      resp_now = busy && cyc >= start_cyc && cyc == resp_cyc;
      if (resp_now) begin pmem_resp = 1; pmem_rdata = mem_line(exp_addr); end
      else if (!(busy && cyc >= start_cyc)) begin pmem_resp = ($urandom_range(0, 5) == 0); pmem_rdata = rand_line(); end
      else begin pmem_resp = 0; pmem_rdata = rand_line(); end
      #1;
      n_tests++;
      if (busy && cyc >= start_cyc) begin
        if (pmem_read !== !exp_wr || pmem_write !== exp_wr || pmem_addr !== exp_addr ||
            (exp_wr && pmem_wdata !== exp_wd)) begin
          n_fail++; $display("FAIL rand_pmem c%0d: rd=%b wr=%b addr=%h expected wr=%b addr=%h", cyc, pmem_read, pmem_write, pmem_addr, exp_wr, exp_addr);
        end
        n_tests++;
        if (i_resp !== (resp_now && own_i) || d_resp !== (resp_now && !own_i) ||
            (resp_now && own_i && i_rdata !== mem_line(exp_addr)) ||
            (resp_now && !own_i && d_rdata !== mem_line(exp_addr))) begin
          n_fail++; $display("FAIL rand_resp c%0d: i_resp=%b d_resp=%b expected resp=%b to I=%b", cyc, i_resp, d_resp, resp_now, own_i);
        end
      end else begin
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || i_rdata !== '0 || d_rdata !== '0) begin
          n_fail++; $display("FAIL rand_idle c%0d: rd/wr/iresp/dresp=%b expected 0000", cyc, {pmem_read, pmem_write, i_resp, d_resp});
        end
      end
      // End-of-cycle model update: completion, then arbitration, then cache behaviour.
      if (resp_now) begin
        busy = 0;
        free_at = cyc + 2;
        if (own_i) begin i_pend = 0; i_hold = $urandom_range(0, 1); i_gap = $urandom_range(0, 3); end
        else begin d_pend = 0; d_hold = $urandom_range(0, 1); d_gap = $urandom_range(0, 3); end
      end else if (!busy && cyc >= free_at && (ireq || dreq)) begin
        if (dreq && ireq && streak >= MAX_D) begin own_i = 1; streak = 0; end
        else if (dreq) begin own_i = 0; streak = ireq ? streak + 1 : 0; end
        else begin own_i = 1; streak = 0; end
        busy = 1;
        start_cyc = cyc + 1;
        lat = $urandom_range(0, 3);
        resp_cyc = start_cyc + lat;
        exp_addr = own_i ? {ia[31:5], 5'b0} : {da[31:5], 5'b0};
        exp_wr = !own_i && d_wr;
        exp_wd = dwd;
      end
      if (!(resp_now && own_i)) begin
        if (i_hold) i_hold = 0;
        else if (!i_pend) begin
          if (i_gap == 0) begin i_pend = 1; ia = $urandom; end else i_gap--;
        end
      end
      if (!(resp_now && !own_i)) begin
        if (d_hold) d_hold = 0;
        else if (!d_pend) begin
          if (d_gap == 0) begin d_pend = 1; da = $urandom; d_wr = $urandom_range(0, 1); dwd = rand_line(); end
          else d_gap--;
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_simultaneous();
    test_starvation();
    test_writeback();
    test_held_and_spurious();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
